// File: rtl/gtech_fjk_pkg.sv
// rtl/gtech_fjk_pkg.sv - shared mode type and mode constants for the JK flip-flop bank
package gtech_fjk_pkg;

    typedef logic [1:0] fjk_mode_t;

    localparam fjk_mode_t FJK_MODE_JK = 2'b00;
    localparam fjk_mode_t FJK_MODE_UP = 2'b01;
    localparam fjk_mode_t FJK_MODE_DN = 2'b10;
    localparam fjk_mode_t FJK_MODE_LD = 2'b11;

endpackage

// File: rtl/gtech_fjk_cell.sv
// rtl/gtech_fjk_cell.sv - single JK flip-flop, sync active-low reset, enable, scan mux under GTECH_FJK_SCAN_EN
module gtech_fjk_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rn,
    input  logic en,
    input  logic j,
    input  logic k,
`ifdef GTECH_FJK_SCAN_EN
    input  logic te,
    input  logic ti,
`endif
    output logic q
);

    // Reset beats scan, scan beats enable; JK action only when enabled
    always_ff @(posedge clk) begin
        if (!rn) begin
            q <= RESET_BIT;
        end
`ifdef GTECH_FJK_SCAN_EN
        else if (te) begin
            q <= ti;
        end
`endif
        else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/gtech_fjk_bank.sv
// rtl/gtech_fjk_bank.sv - bank of JK flip-flops with JK/up/down/load modes; scan chain under GTECH_FJK_SCAN_EN
module gtech_fjk_bank
    import gtech_fjk_pkg::*;
#(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CP,
    input  logic             RN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
`ifdef GTECH_FJK_SCAN_EN
    input  logic             TE,
    input  logic             TI,
    output logic             TQ,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC
);

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;

    // Ripple carry/borrow: bit i toggles once every lower bit is all-ones (up) or all-zeros (down)
    always_comb begin
        carry     = '0;
        borrow    = '0;
        carry[0]  = 1'b1;
        borrow[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i]  = carry[i-1] & Q[i-1];
            borrow[i] = borrow[i-1] & ~Q[i-1];
        end
    end

    // Map the bank mode onto each cell's J/K pair; load sets or clears every bit from D
    always_comb begin
        j_eff = J;
        k_eff = K;
        case (MODE)
            FJK_MODE_UP: begin
                j_eff = carry;
                k_eff = carry;
            end
            FJK_MODE_DN: begin
                j_eff = borrow;
                k_eff = borrow;
            end
            FJK_MODE_LD: begin
                j_eff = D;
                k_eff = ~D;
            end
            default: begin
                j_eff = J;
                k_eff = K;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
`ifdef GTECH_FJK_SCAN_EN
            logic scan_in;
            if (gi == 0) begin : g_first
                assign scan_in = TI;
            end else begin : g_rest
                assign scan_in = Q[gi-1];
            end
`endif
            gtech_fjk_cell #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_cell (
                .clk (CP),
                .rn  (RN),
                .en  (EN),
                .j   (j_eff[gi]),
                .k   (k_eff[gi]),
`ifdef GTECH_FJK_SCAN_EN
                .te  (TE),
                .ti  (scan_in),
`endif
                .q   (Q[gi])
            );
        end
    endgenerate

    assign QN = ~Q;
    assign TC = EN & (((MODE == FJK_MODE_UP) & (&Q)) | ((MODE == FJK_MODE_DN) & ~(|Q)));

`ifdef GTECH_FJK_SCAN_EN
    assign TQ = Q[WIDTH-1];
`endif

endmodule
